// File: rtl/alu_pkg.sv
// alu_pkg: op encodings shared by step_counter and ALU decode.
package alu_pkg;
    typedef logic [1:0] op_t;
    localparam op_t OP_HOLD = 2'b00;
    localparam op_t OP_INC  = 2'b01;
    localparam op_t OP_DEC  = 2'b10;
    localparam op_t OP_LOAD = 2'b11;
endpackage

// File: rtl/step_counter_if.sv
// step_counter_if: control inputs and status outputs of the step counter.
interface step_counter_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic             en;
    op_t              op;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] q;
    logic             c_out;
    logic             ovf;
    logic             zero;
    modport master (output en, op, step, load_val, clr_ovf, input q, c_out, ovf, zero);
    modport slave  (input en, op, step, load_val, clr_ovf, output q, c_out, ovf, zero);
endinterface

// File: rtl/addsub_n.sv
// addsub_n: WIDTH-bit unsigned adder/subtractor; o_co is carry on add, borrow on subtract.
module addsub_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_y,
    output logic             o_co
);
    logic [WIDTH:0] w_r;
    assign w_r = i_sub ? {1'b0, i_a} - {1'b0, i_b} : {1'b0, i_a} + {1'b0, i_b};
    assign o_y  = w_r[WIDTH-1:0];
    assign o_co = w_r[WIDTH];
endmodule

// File: rtl/step_counter.sv
// step_counter: registered inc/dec/load counter with carry/borrow pulse, sticky ovf and zero flag.
// Define STEP_COUNTER_SAT_EN to saturate q on carry/borrow instead of wrapping.
module step_counter
    import alu_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic           clk,
    input logic           rst_n,
    step_counter_if.slave bus
);
    logic [WIDTH-1:0] r_q;
    logic             r_c_out;
    logic             r_ovf;
    logic             w_inc;
    logic             w_dec;
    logic             w_co;
    logic             w_c_next;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_q_next;

    assign w_inc = bus.en && (bus.op == OP_INC);
    assign w_dec = bus.en && (bus.op == OP_DEC);

    addsub_n #(.WIDTH(WIDTH)) u_addsub (
        .i_a   (r_q),
        .i_b   (bus.step),
        .i_sub (w_dec),
        .o_y   (w_sum),
        .o_co  (w_co)
    );

    assign w_c_next = (w_inc || w_dec) && w_co;

    always_comb begin
`ifdef STEP_COUNTER_SAT_EN
        w_q_next = (bus.en && bus.op == OP_LOAD) ? bus.load_val :
                   w_c_next                      ? {WIDTH{w_inc}} :
                   (w_inc || w_dec)              ? w_sum : r_q;
`else
        w_q_next = (bus.en && bus.op == OP_LOAD) ? bus.load_val :
                   (w_inc || w_dec)              ? w_sum : r_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q     <= RESET_VAL;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_q     <= w_q_next;
            r_c_out <= w_c_next;
            r_ovf   <= (r_ovf && !bus.clr_ovf) || w_c_next;
        end
    end

    assign bus.q     = r_q;
    assign bus.c_out = r_c_out;
    assign bus.ovf   = r_ovf;
    assign bus.zero  = (r_q == '0);
endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: directed plus random stimulus against an integer reference model, scoreboard-checked.
module tb_step_counter;
    localparam int         W  = 4;
    localparam logic [3:0] RV = 4'h3;
`ifdef STEP_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    step_counter_if #(.WIDTH(W)) bus ();
    step_counter #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int q;
        int c;
        int o;
    } exp_t;
    exp_t sb[$];

    int mq = 3;
    int mc = 0;
    int mo = 0;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive(input bit r, input bit e, input int op, input int st, input int lv, input bit clr);
        int nq;
        int nc;
        @(negedge clk);
        rst_n = r;
        bus.en = e;
        bus.op = op[1:0];
        bus.step = st[3:0];
        bus.load_val = lv[3:0];
        bus.clr_ovf = clr;
        if (!r) begin
            mq = 3;
            mc = 0;
            mo = 0;
        end else begin
            nq = mq;
            nc = 0;
            if (e && op == 1) begin
                nq = mq + st;
                nc = (nq > 15) ? 1 : 0;
                if (nc != 0) nq = SAT ? 15 : nq - 16;
            end else if (e && op == 2) begin
                nq = mq - st;
                nc = (nq < 0) ? 1 : 0;
                if (nc != 0) nq = SAT ? 0 : nq + 16;
            end else if (e && op == 3) begin
                nq = lv;
            end
            mo = ((mo != 0 && !clr) || nc != 0) ? 1 : 0;
            mq = nq;
            mc = nc;
        end
        sb.push_back('{mq, mc, mo});
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("q", int'(bus.q), x.q);
                chk("c_out", int'(bus.c_out), x.c);
                chk("ovf", int'(bus.ovf), x.o);
                chk("zero", int'(bus.zero), (x.q == 0) ? 1 : 0);
            end
        end
    end

    initial begin
        int n;
        bus.en = 1'b0;
        bus.op = 2'b00;
        bus.step = '0;
        bus.load_val = '0;
        bus.clr_ovf = 1'b0;
        drive(0, 1, 1, 1, 0, 0);
        drive(1, 1, 1, 1, 0, 0);
        drive(1, 1, 3, 0, 10, 0);
        drive(1, 1, 1, 1, 0, 0);
        drive(1, 1, 1, 1, 0, 0);
        drive(1, 1, 3, 0, 14, 0);
        drive(1, 1, 1, 3, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 3, 0, 2, 0);
        drive(1, 1, 2, 5, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 3, 0, 15, 0);
        drive(1, 1, 1, 1, 0, 1);
        drive(1, 1, 0, 0, 0, 1);
        drive(1, 1, 1, 0, 0, 0);
        drive(1, 1, 2, 0, 0, 0);
        drive(1, 1, 3, 0, 0, 0);
        drive(1, 0, 3, 0, 5, 0);
        drive(1, 0, 1, 4, 0, 0);
        drive(1, 1, 1, 2, 0, 0);
        drive(0, 1, 2, 7, 0, 0);
        drive(1, 1, 2, 4, 0, 0);
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 19) != 0, $urandom_range(0, 5) != 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        end
        drive(1, 0, 0, 0, 0, 0);
        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
